// File: rtl/queue_ctrl_2x55.sv
// queue_ctrl_2x55: pointer and full/empty control for a 2-entry, 55-bit ready/valid
// queue built around the external ram_2x55 macro (1 write port, 1 read port).
// The macro is instantiated by the parent; this block drives its W0/R0 ports.
//
// Optional build macro: QUEUE_CTRL_FLOW_EN
//   When defined, an empty queue forwards io_enq_bits straight to the dequeue side in
//   the same cycle. If the consumer takes it, nothing is written to the RAM.
module queue_ctrl_2x55 (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_flush,
    input  logic        io_enq_valid,
    output logic        io_enq_ready,
    input  logic [54:0] io_enq_bits,
    output logic        io_deq_valid,
    input  logic        io_deq_ready,
    output logic [54:0] io_deq_bits,
    output logic [1:0]  io_count,
    output logic        ram_W0_addr,
    output logic        ram_W0_en,
    output logic [54:0] ram_W0_data,
    output logic        ram_R0_addr,
    output logic        ram_R0_en,
    input  logic [54:0] ram_R0_data
);

    logic enq_ptr_q, enq_ptr_d;
    logic deq_ptr_q, deq_ptr_d;
    logic maybe_full_q, maybe_full_d;

    logic clear;
    logic match;
    logic empty;
    logic full;
    logic bypass;
    logic do_enq;
    logic do_deq;
    logic ram_enq;
    logic ram_deq;

    assign clear = reset | io_flush;
    assign match = (enq_ptr_q == deq_ptr_q);
    assign empty = match & ~maybe_full_q;
    assign full  = match & maybe_full_q;

`ifdef QUEUE_CTRL_FLOW_EN
    // Same-cycle forwarding is only possible while the RAM holds nothing.
    assign bypass = empty & io_enq_valid & ~clear;
`else
    assign bypass = 1'b0;
`endif

    // Handshakes, macro drive and dequeue data; clear suppresses every transfer.
    always_comb begin
        io_enq_ready = ~full & ~clear;
        io_deq_valid = (~empty | bypass) & ~clear;
        do_enq       = io_enq_valid & io_enq_ready;
        do_deq       = io_deq_valid & io_deq_ready;

        // A bypassed item that is consumed immediately never touches the RAM.
        ram_enq      = do_enq & ~(bypass & io_deq_ready);
        ram_deq      = do_deq & ~bypass;

        ram_W0_en    = ram_enq;
        ram_W0_addr  = enq_ptr_q;
        ram_W0_data  = io_enq_bits;
        ram_R0_en    = ~empty & ~reset;
        ram_R0_addr  = deq_ptr_q;

        // Read data is only trusted while R0 is enabled, so X never escapes.
        io_deq_bits = 55'h0;
        if (bypass) begin
            io_deq_bits = io_enq_bits;
        end else if (io_deq_valid) begin
            io_deq_bits = ram_R0_data;
        end

        if (reset) begin
            io_count = 2'd0;
        end else if (full) begin
            io_count = 2'd2;
        end else if (empty) begin
            io_count = 2'd0;
        end else begin
            io_count = 2'd1;
        end
    end

    // Next-state for pointers and the full/empty disambiguation bit.
    always_comb begin
        enq_ptr_d    = enq_ptr_q ^ ram_enq;
        deq_ptr_d    = deq_ptr_q ^ ram_deq;
        maybe_full_d = maybe_full_q;
        if (ram_enq && !ram_deq) begin
            maybe_full_d = 1'b1;
        end else if (ram_deq && !ram_enq) begin
            maybe_full_d = 1'b0;
        end
    end

    // State registers; reset and flush both return the queue to empty.
    always_ff @(posedge clock) begin
        if (clear) begin
            enq_ptr_q    <= 1'b0;
            deq_ptr_q    <= 1'b0;
            maybe_full_q <= 1'b0;
        end else begin
            enq_ptr_q    <= enq_ptr_d;
            deq_ptr_q    <= deq_ptr_d;
            maybe_full_q <= maybe_full_d;
        end
    end

endmodule

// File: doc/queue_ctrl_2x55.md
# queue_ctrl_2x55

Control sequencer for a 2-entry, 55-bit ready/valid queue built around the external `ram_2x55` memory macro (1 write port, 1 read port). It owns the enqueue/dequeue pointers and full/empty tracking, and drives the macro's write and read ports. It presents decoupled enqueue and dequeue interfaces to the surrounding datapath. The parent instantiates `ram_2x55` next to this block and ties both macro clocks to `clock`.

## Interface
- No parameters: width 55 and depth 2 are fixed by the RAM macro.

- `clock`  in  1  sole clock; all state updates on posedge
- `reset`  in  1  synchronous, active-high
- `io_flush`  in  1  synchronous queue clear
- `io_enq_valid`  in  1  producer has data
- `io_enq_ready`  out  1  queue can accept
- `io_enq_bits`  in  55  enqueue payload
- `io_deq_valid`  out  1  queue has data
- `io_deq_ready`  in  1  consumer accepts
- `io_deq_bits`  out  55  dequeue payload
- `io_count`  out  2  occupancy, 0..2
- `ram_W0_addr`  out  1  macro write address
- `ram_W0_en`  out  1  macro write enable
- `ram_W0_data`  out  55  macro write data
- `ram_R0_addr`  out  1  macro read address
- `ram_R0_en`  out  1  macro read enable
- `ram_R0_data`  in  55  macro read data (combinational from R0_addr; X when R0_en=0)

## Operation
- State registers:
  - `enq_ptr` (1b)
  - `deq_ptr` (1b)
  - `maybe_full` (1b)
- Derived signals:
  - match = enq_ptr==deq_ptr
  - empty = match & !maybe_full
  - full = match & maybe_full
- Handshakes:
  - io_enq_ready = !full.
  - io_deq_valid = !empty.
  - do_enq = enq_valid & enq_ready.
  - do_deq = deq_valid & deq_ready.
- Macro port drive:
  - ram_W0_en = do_enq; ram_W0_addr = enq_ptr; ram_W0_data = io_enq_bits.
  - ram_R0_en = !empty; ram_R0_addr = deq_ptr.
- Dequeue data: io_deq_bits = ram_R0_data when io_deq_valid, else 55'h0. X must never reach the output.
- Pointer updates:
  - do_enq toggles enq_ptr.
  - do_deq toggles deq_ptr. The 1-bit pointers wrap 1→0 naturally.
- maybe_full update:
  - do_enq & !do_deq sets it.
  - do_deq & !do_enq clears it.
  - Both or neither: unchanged.
- io_count: full → 2, empty → 0, otherwise 1.
- Simultaneous enq+deq:
  - When full, enq_ready=0, so only the dequeue proceeds.
  - At count 1, both proceed and the count stays 1.
- Flush / reset:
  - Highest priority.
  - Next state: enq_ptr = deq_ptr = maybe_full = 0.
  - During a flush or reset cycle, force io_enq_ready=0, io_deq_valid=0, and ram_W0_en=0. Any enq/deq offered that cycle is dropped, with no handshake.
  - RAM contents are not cleared.
- Reset output values, while reset is high: io_enq_ready=0, io_deq_valid=0, io_deq_bits=0, io_count=0, ram_W0_en=0, ram_R0_en=0.

## Timing
- All outputs are combinational from state plus io_flush/reset.
  - io_enq_ready has no combinational path from io_deq_ready.
  - io_deq_valid has no path from io_enq_valid, except in flow mode (see Configuration).
- Enqueue-to-dequeue latency: 1 cycle. Data written at edge N is presented at io_deq_bits after edge N; io_deq_valid rises in cycle N+1.
- Throughput: 1 transfer/cycle sustained at count 1 with both sides active.
- First cycle after reset or flush deasserts: io_enq_ready=1, io_deq_valid=0, io_count=0.

## Configuration
- `QUEUE_CTRL_FLOW_EN`, defined:
  - When empty and io_enq_valid=1, io_deq_valid=1 and io_deq_bits=io_enq_bits in the same cycle.
  - If io_deq_ready=1 in that cycle: no RAM write, no pointer or maybe_full change, and io_enq_ready stays 1.
  - If io_deq_ready=0: a normal enqueue occurs.
  - Flush/reset still force io_deq_valid=0.
- Undefined: no bypass; an empty queue always reports io_deq_valid=0 (behaviour as in Operation).

## Test plan
- Reset held 3 cycles with enq_valid=1 → enq_ready=0, deq_valid=0, count=0, W0_en=0 throughout. First post-reset cycle: enq_ready=1.
- Fill then stall:
  - Enqueue 55'h0AA then 55'h155 with deq_ready=0 → count 1 then 2, enq_ready=0.
  - Third enq_valid is not accepted; deq_bits=55'h0AA.
- Drain with pointer wrap:
  - From full, deq_ready=1 for 2 cycles → outputs 55'h0AA then 55'h155, count returns to 0.
  - Enqueue 55'h7 → written at address 0 after wrap, dequeued correctly.
- Streaming: at count 1, enq and deq both active for 10 cycles with an incrementing payload → count stays 1, output order equals input order, no drops.
- Flush with full queue plus simultaneous enq_valid/deq_ready → no handshake that cycle; next cycle count=0, deq_valid=0, deq_bits=0.
- With QUEUE_CTRL_FLOW_EN, empty queue, enq 55'h1234 with deq_ready=1 → deq_valid=1 and deq_bits=55'h1234 in the same cycle, W0_en=0, count stays 0. Without the macro, the same stimulus gives deq_valid=0 that cycle and 55'h1234 the next cycle.
